cmd_uart_wrapper: RTL and testbench

- Serial front end of the Knight: receives 2-byte commands from the remote (Bluetooth) link over UART and presents them as one 16-bit command to the command processor.
- Also serialises the 8-bit response (e.g. 0xA5 positive ack, 0x5A move ack) back to the remote.
- Contains its own 8N1 receiver, 8N1 transmitter and byte-assembly state machine; sits between the top-level RX/TX pins and cmd_proc.

---
 rtl/cmd_uart_wrapper.sv | 209 ++++++++++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_wrapper.sv
// UART command front end: 8N1 receiver, two-byte command assembly and 8N1
// response transmitter. Receive and transmit paths run independently.
module cmd_uart_wrapper #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  // Counter must hold 1.5 bit periods at the largest divider.
  localparam int unsigned CNT_W = 17;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] BIT_RELOAD   = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] FIRST_RELOAD = CNT_W'(BAUD_DIV + BAUD_DIV / 2 - 1);

  typedef enum logic { RX_IDLE, RX_BUSY } rx_state_t;
  typedef enum logic { ASM_HIGH, ASM_LOW } asm_state_t;
  typedef enum logic { TX_IDLE, TX_BUSY } tx_state_t;

  // ---------------------------------------------------------------- receiver
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0] rx_bits, rx_bits_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_byte_rdy_c;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bits  <= rx_bits_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // Receiver next state: mid-bit sampling, 8 data bits then the stop bit.
  always_comb begin
    rx_state_nxt  = rx_state;
    rx_cnt_nxt    = rx_cnt;
    rx_bits_nxt   = rx_bits;
    rx_shift_nxt  = rx_shift;
    rx_byte_rdy_c = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nxt = RX_BUSY;
          rx_cnt_nxt   = FIRST_RELOAD;
          rx_bits_nxt  = '0;
        end
      end
      RX_BUSY: begin
        if (rx_cnt != '0) begin
          rx_cnt_nxt = rx_cnt - CNT_W'(1);
        end else if (rx_bits == BIT_W'(8)) begin
          // Stop-bit sample: a low stop bit silently drops the byte.
          rx_state_nxt  = RX_IDLE;
          rx_byte_rdy_c = rx_sync;
        end else begin
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_bits_nxt  = rx_bits + BIT_W'(1);
          rx_cnt_nxt   = BIT_RELOAD;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- assembly
  asm_state_t  asm_state, asm_state_nxt;
  logic [7:0]  high_byte, high_byte_nxt;
  logic [15:0] cmd_nxt;
  logic        cmd_rdy_nxt;

  // Assembly state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= ASM_HIGH;
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      asm_state <= asm_state_nxt;
      high_byte <= high_byte_nxt;
      cmd       <= cmd_nxt;
      cmd_rdy   <= cmd_rdy_nxt;
    end
  end

  // Pair bytes into a command; a completing byte beats a same-cycle clear.
  always_comb begin
    asm_state_nxt = asm_state;
    high_byte_nxt = high_byte;
    cmd_nxt       = cmd;
    cmd_rdy_nxt   = cmd_rdy;
    if (clr_cmd_rdy) begin
      cmd_rdy_nxt = 1'b0;
    end
    unique case (asm_state)
      ASM_HIGH: begin
        if (rx_byte_rdy_c) begin
          high_byte_nxt = rx_shift;
          asm_state_nxt = ASM_LOW;
          cmd_rdy_nxt   = 1'b0;
        end
      end
      ASM_LOW: begin
        if (rx_byte_rdy_c) begin
          cmd_nxt       = {high_byte, rx_shift};
          asm_state_nxt = ASM_HIGH;
          cmd_rdy_nxt   = 1'b1;
        end
      end
      default: asm_state_nxt = ASM_HIGH;
    endcase
  end

  // ------------------------------------------------------------- transmitter
  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0] tx_bits, tx_bits_nxt;
  logic [8:0]       tx_shift, tx_shift_nxt;
  logic             tx_pin_nxt, tx_done_nxt;

  // Transmitter state register; the line itself is a flop held high in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bits  <= tx_bits_nxt;
      tx_shift <= tx_shift_nxt;
      TX       <= tx_pin_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  // Transmitter next state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bits_nxt  = tx_bits;
    tx_shift_nxt = tx_shift;
    tx_pin_nxt   = TX;
    tx_done_nxt  = tx_done;
    unique case (tx_state)
      TX_IDLE: begin
        tx_pin_nxt = 1'b1;
        if (trmt) begin
          tx_state_nxt = TX_BUSY;
          tx_shift_nxt = {1'b1, resp};
          tx_bits_nxt  = '0;
          tx_cnt_nxt   = BIT_RELOAD;
          tx_pin_nxt   = 1'b0;
          tx_done_nxt  = 1'b0;
        end
      end
      TX_BUSY: begin
        if (tx_cnt != '0) begin
          tx_cnt_nxt = tx_cnt - CNT_W'(1);
        end else if (tx_bits == BIT_W'(9)) begin
          tx_state_nxt = TX_IDLE;
          tx_done_nxt  = 1'b1;
          tx_pin_nxt   = 1'b1;
        end else begin
          tx_pin_nxt   = tx_shift[0];
          tx_shift_nxt = {1'b1, tx_shift[8:1]};
          tx_bits_nxt  = tx_bits + BIT_W'(1);
          tx_cnt_nxt   = BIT_RELOAD;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Scoreboard bench for cmd_uart_wrapper: stimulus pushes expected commands and
// responses, independent monitors decode cmd_rdy rises and the TX line.
module tb_cmd_uart_wrapper;

  localparam int unsigned B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rise_cyc = 0;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];
  bit          pend_valid = 1'b0;
  logic [7:0]  pend_byte = 8'h00;

  cmd_uart_wrapper #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Command monitor: every cmd_rdy rise must match the next expected command.
  initial begin : cmd_mon
    logic q;
    q = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && !q) begin
        last_rise_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got 0x%0h expected none", cmd);
        end else begin
          check("cmd", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
        end
      end
      q = (cmd_rdy === 1'b1);
    end
  end

  // TX monitor: decode each frame, checking every bit at both ends of its period.
  initial begin : tx_mon
    logic       prev;
    logic [9:0] early, late, expv;
    logic       d_before, d_after;
    logic [7:0] r;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && TX === 1'b0) begin
        for (int i = 0; i < 10; i++) begin
          early[i] = TX;
          repeat (B - 1) @(negedge clk);
          late[i] = TX;
          if (i == 9) d_before = tx_done;
          @(negedge clk);
        end
        d_after = tx_done;
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got frame 0x%0h expected none", early);
        end else begin
          r    = exp_resp_q.pop_front();
          expv = {1'b1, r, 1'b0};
          check("tx_bits_start", {22'h0, early}, {22'h0, expv});
          check("tx_bits_end", {22'h0, late}, {22'h0, expv});
          check("tx_done_timing", {30'h0, d_before, d_after}, 32'h1);
        end
      end
      prev = (TX !== 1'b0);
    end
  end

  // Raw 8N1 frame on RX; start_cyc is the cycle count when the start bit begins.
  task automatic drive_frame(input logic [7:0] b, input logic stop, output int unsigned start_cyc);
    @(negedge clk);
    start_cyc = cyc;
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference model: good bytes pair up as {first, second}; bad-stop bytes vanish.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int unsigned start_cyc);
    if (stop) begin
      if (pend_valid) begin
        exp_cmd_q.push_back({pend_byte, b});
        pend_valid = 1'b0;
      end else begin
        pend_byte  = b;
        pend_valid = 1'b1;
      end
    end
    drive_frame(b, stop, start_cyc);
  endtask

  task automatic pulse_trmt(input logic [7:0] r, input bit accept);
    @(negedge clk);
    resp = r;
    trmt = 1'b1;
    if (accept) exp_resp_q.push_back(r);
    @(negedge clk);
    trmt = 1'b0;
  endtask

  task automatic wait_tx_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tx_done_wait", {31'h0, ok}, 32'h1);
  endtask

  initial begin : watchdog
    #(400000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int unsigned st;
    int          d;
    bit          ok, seen;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, TX}, 32'h1);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("reset_tx_done", {31'h0, tx_done}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command, latency and clear.
    send_byte(8'h70, 1'b1, st);
    send_byte(8'h20, 1'b1, st);
    d = int'(last_rise_cyc) - int'(st);
    ok = (d >= int'(B * 19 / 2 + 1)) && (d <= int'(B * 19 / 2 + 4));
    check("cmd_rdy_latency_ok", {31'h0, ok}, 32'h1);
    check("cmd_rdy_set", {31'h0, cmd_rdy}, 32'h1);
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", {31'h0, cmd_rdy}, 32'h0);
    check("cmd_held_after_clr", {16'h0, cmd}, 32'h7020);

    // Response transmit with an ignored mid-frame trmt.
    pulse_trmt(8'h5A, 1'b1);
    repeat (3 * B) @(negedge clk);
    pulse_trmt(8'hFF, 1'b0);
    wait_tx_done(12 * B);
    repeat (2 * B) @(negedge clk);
    check("tx_done_holds", {31'h0, tx_done}, 32'h1);
    check("tx_idle_high", {31'h0, TX}, 32'h1);

    // Framing error drops a byte.
    send_byte(8'h06, 1'b0, st);
    send_byte(8'h29, 1'b1, st);
    send_byte(8'h00, 1'b1, st);
    check("cmd_after_framing", {16'h0, cmd}, 32'h2900);
    check("cmd_rdy_after_framing", {31'h0, cmd_rdy}, 32'h1);

    // Reset in the middle of the second byte loses the pending high byte.
    send_byte(8'h40, 1'b1, st);
    ok = 1'b1;
    fork
      drive_frame(8'hF0, 1'b1, st);
      begin
        repeat (6 * B + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        ok = ok & (TX === 1'b1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          ok = ok & (TX === 1'b1);
        end
        check("cmd_in_reset", {16'h0, cmd}, 32'h0);
        check("cmd_rdy_in_reset", {31'h0, cmd_rdy}, 32'h0);
        rst_n = 1'b1;
        pend_valid = 1'b0;
      end
    join
    check("tx_high_in_reset", {31'h0, ok}, 32'h1);
    repeat (4) @(negedge clk);
    send_byte(8'h41, 1'b1, st);
    send_byte(8'h52, 1'b1, st);
    check("cmd_after_reset", {16'h0, cmd}, 32'h4152);

    // Back-to-back commands, then clear coinciding with completion.
    send_byte(8'h20, 1'b1, st);
    send_byte(8'h00, 1'b1, st);
    check("b2b_first_cmd", {16'h0, cmd}, 32'h2000);
    send_byte(8'h30, 1'b1, st);
    check("b2b_rdy_dropped", {31'h0, cmd_rdy}, 32'h0);
    check("b2b_cmd_held", {16'h0, cmd}, 32'h2000);
    seen = 1'b0;
    fork
      send_byte(8'h01, 1'b1, st);
      begin
        clr_cmd_rdy = 1'b1;
        for (int i = 0; i < 12 * int'(B); i++) begin
          @(negedge clk);
          if (cmd_rdy === 1'b1) begin
            clr_cmd_rdy = 1'b0;
            seen = 1'b1;
            break;
          end
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    check("set_beats_clr", {31'h0, seen}, 32'h1);
    repeat (3) @(negedge clk);
    check("b2b_rdy_final", {31'h0, cmd_rdy}, 32'h1);
    check("b2b_second_cmd", {16'h0, cmd}, 32'h3001);

    // Concurrent transmit and receive.
    fork
      pulse_trmt(8'hA5, 1'b1);
      begin
        send_byte(8'h4A, 1'b1, st);
        send_byte(8'hBC, 1'b1, st);
      end
    join
    wait_tx_done(12 * B);
    check("conc_cmd", {16'h0, cmd}, 32'h4ABC);
    check("conc_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Randomised traffic on both paths.
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          send_byte(8'($urandom), ($urandom_range(0, 4) != 0), st);
          repeat ($urandom_range(0, 7)) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 5; n++) begin
          wait_tx_done(12 * B);
          repeat ($urandom_range(0, 20)) @(negedge clk);
          pulse_trmt(8'($urandom), 1'b1);
        end
        wait_tx_done(12 * B);
      end
    join

    repeat (20) @(negedge clk);
    check("cmd_queue_drained", exp_cmd_q.size(), 32'h0);
    check("resp_queue_drained", exp_resp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
